ram_arbiter: RTL and testbench

Two-port arbiter sharing one RAM port between two caches: port 0 (instruction cache) and port 1 (data cache). It grants the RAM to one cache at a time and holds the grant for that cache's whole transaction, including a write-back burst followed directly by a fill burst. Requests, addresses and write data pass to the RAM from the owner only; RAM read data and acknowledges return to the owner only. It sits between the caches' RAM-side ports and the memory controller.

---
 rtl/ram_arbiter_pkg.sv | 12 +
 rtl/ram_arbiter_rr_pick.sv | 16 +
 rtl/ram_arbiter.sv | 89 ++++++++
 tb/tb_ram_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: one-hot state encoding and port count.
package ram_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    GRANT0 = 3'b010,
    GRANT1 = 3'b100
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin pick between two requesters; on contention the port that was not granted last wins.
module ram_arbiter_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) pick = ~last;
    else              pick = req1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the instruction cache (port 0) and data cache (port 1),
// holding the grant for the owner's whole request window, write-back plus fill included.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter bit STARTPORT = 1'b0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Schreiben0,
  input  logic                 Schreiben1,
  input  logic                 Lesen0,
  input  logic                 Lesen1,
  input  logic [31:0]          Adresse0,
  input  logic [31:0]          Adresse1,
  input  logic [31:0]          SchreibDaten0,
  input  logic [31:0]          SchreibDaten1,
  output logic [31:0]          LesDaten0,
  output logic [31:0]          LesDaten1,
  output logic                 DatenGeschrieben0,
  output logic                 DatenGeschrieben1,
  output logic                 DatenGelesen0,
  output logic                 DatenGelesen1,
  input  logic [31:0]          RAMLesDaten,
  input  logic                 RAMDatenGeschrieben,
  input  logic                 RAMDatenGelesen,
  output logic                 RAMSchreiben,
  output logic                 RAMLesen,
  output logic [31:0]          RAMAdresse,
  output logic [31:0]          RAMSchreibDaten,
  output logic [NUM_PORTS-1:0] Grant
);

  arb_state_t state, state_next;
  logic       last;
  logic       req0, req1;
  logic       pick, pick_valid;
  logic       own0, own1;

  assign req0 = Schreiben0 | Lesen0;
  assign req1 = Schreiben1 | Lesen1;

  ram_arbiter_rr_pick u_rr_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      GRANT0:  if (!req0) state_next = !pick_valid ? IDLE : (pick ? GRANT1 : GRANT0);
      GRANT1:  if (!req1) state_next = !pick_valid ? IDLE : (pick ? GRANT1 : GRANT0);
      IDLE:    if (pick_valid) state_next = pick ? GRANT1 : GRANT0;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      last  <= ~STARTPORT;
    end else begin
      state <= state_next;
      if (state_next == GRANT0)      last <= 1'b0;
      else if (state_next == GRANT1) last <= 1'b1;
    end
  end

  assign own0  = (state == GRANT0);
  assign own1  = (state == GRANT1);
  assign Grant = {own1, own0};

  assign RAMSchreiben    = (own0 & Schreiben0) | (own1 & Schreiben1);
  assign RAMLesen        = (own0 & Lesen0)     | (own1 & Lesen1);
  assign RAMAdresse      = ({32{own0}} & Adresse0)      | ({32{own1}} & Adresse1);
  assign RAMSchreibDaten = ({32{own0}} & SchreibDaten0) | ({32{own1}} & SchreibDaten1);

  // Acks seen during a reset cycle belong to an aborted transaction and are dropped.
  assign DatenGeschrieben0 = own0 & RAMDatenGeschrieben & ~Reset;
  assign DatenGeschrieben1 = own1 & RAMDatenGeschrieben & ~Reset;
  assign DatenGelesen0     = own0 & RAMDatenGelesen & ~Reset;
  assign DatenGelesen1     = own1 & RAMDatenGelesen & ~Reset;
  assign LesDaten0         = own0 ? RAMLesDaten : 32'd0;
  assign LesDaten1         = own1 ? RAMLesDaten : 32'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_ram_arbiter;

  localparam bit START = 1'b0;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Schreiben0, Schreiben1, Lesen0, Lesen1;
  logic [31:0] Adresse0, Adresse1, SchreibDaten0, SchreibDaten1;
  logic [31:0] LesDaten0, LesDaten1;
  logic        DatenGeschrieben0, DatenGeschrieben1, DatenGelesen0, DatenGelesen1;
  logic [31:0] RAMLesDaten;
  logic        RAMDatenGeschrieben, RAMDatenGelesen;
  logic        RAMSchreiben, RAMLesen;
  logic [31:0] RAMAdresse, RAMSchreibDaten;
  logic [1:0]  Grant;

  ram_arbiter #(.STARTPORT(START)) dut (
    .Clock(Clock), .Reset(Reset),
    .Schreiben0(Schreiben0), .Schreiben1(Schreiben1),
    .Lesen0(Lesen0), .Lesen1(Lesen1),
    .Adresse0(Adresse0), .Adresse1(Adresse1),
    .SchreibDaten0(SchreibDaten0), .SchreibDaten1(SchreibDaten1),
    .LesDaten0(LesDaten0), .LesDaten1(LesDaten1),
    .DatenGeschrieben0(DatenGeschrieben0), .DatenGeschrieben1(DatenGeschrieben1),
    .DatenGelesen0(DatenGelesen0), .DatenGelesen1(DatenGelesen1),
    .RAMLesDaten(RAMLesDaten),
    .RAMDatenGeschrieben(RAMDatenGeschrieben), .RAMDatenGelesen(RAMDatenGelesen),
    .RAMSchreiben(RAMSchreiben), .RAMLesen(RAMLesen),
    .RAMAdresse(RAMAdresse), .RAMSchreibDaten(RAMSchreibDaten),
    .Grant(Grant)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the RAM (-1 = nobody) and who was granted most recently.
  int m_owner = -1;
  bit m_last;
  bit m_valid = 1'b0;
  bit m_r0, m_r1, m_hold;

  always @(posedge Clock) begin
    m_r0 = Schreiben0 | Lesen0;
    m_r1 = Schreiben1 | Lesen1;
    m_hold = (m_owner == 0 && m_r0) || (m_owner == 1 && m_r1);
    if (Reset) begin
      m_owner = -1;
      m_last  = ~START;
      m_valid = 1'b1;
    end else if (!m_hold) begin
      if (m_r0 && m_r1) m_owner = m_last ? 0 : 1;
      else if (m_r0)    m_owner = 0;
      else if (m_r1)    m_owner = 1;
      else              m_owner = -1;
      if (m_owner >= 0) m_last = (m_owner == 1);
    end
  end

  logic e0, e1;
  always @(negedge Clock) begin
    if (m_valid) begin
      e0 = (m_owner == 0);
      e1 = (m_owner == 1);
      check("grant", {30'd0, Grant}, {30'd0, e1, e0});
      check("ram_wr", {31'd0, RAMSchreiben}, {31'd0, e0 ? Schreiben0 : e1 ? Schreiben1 : 1'b0});
      check("ram_rd", {31'd0, RAMLesen},     {31'd0, e0 ? Lesen0 : e1 ? Lesen1 : 1'b0});
      check("ram_addr", RAMAdresse,      e0 ? Adresse0 : e1 ? Adresse1 : 32'd0);
      check("ram_wdata", RAMSchreibDaten, e0 ? SchreibDaten0 : e1 ? SchreibDaten1 : 32'd0);
      check("rdata0", LesDaten0, e0 ? RAMLesDaten : 32'd0);
      check("rdata1", LesDaten1, e1 ? RAMLesDaten : 32'd0);
      check("acks", {28'd0, DatenGeschrieben0, DatenGeschrieben1, DatenGelesen0, DatenGelesen1},
            {28'd0, e0 & RAMDatenGeschrieben & ~Reset, e1 & RAMDatenGeschrieben & ~Reset,
                    e0 & RAMDatenGelesen & ~Reset,     e1 & RAMDatenGelesen & ~Reset});
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    Schreiben0 = 0; Schreiben1 = 0; Lesen0 = 0; Lesen1 = 0;
    Adresse0 = 0; Adresse1 = 0; SchreibDaten0 = 0; SchreibDaten1 = 0;
    RAMLesDaten = 0; RAMDatenGeschrieben = 0; RAMDatenGelesen = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1;
    step();
    Reset = 0;
  endtask

  int h0, h1;

  initial begin
    Reset = 1;
    clear_inputs();
    step();
    step();
    Reset = 0;

    // reset state
    check("rst_grant", {30'd0, Grant}, 32'd0);
    check("rst_ramaddr", RAMAdresse, 32'd0);
    check("rst_ramrd", {31'd0, RAMLesen}, 32'd0);

    // single requester on port 0
    Lesen0 = 1; Adresse0 = 32'h100;
    step();
    check("single_grant", {30'd0, Grant}, 32'd1);
    check("single_addr", RAMAdresse, 32'h100);
    for (int i = 0; i < 4; i++) begin
      RAMDatenGelesen = 1;
      #1;
      check("single_ack0", {31'd0, DatenGelesen0}, 32'd1);
      check("single_ack1", {31'd0, DatenGelesen1}, 32'd0);
      step();
    end
    RAMDatenGelesen = 0; Lesen0 = 0;
    step();
    check("single_release", {30'd0, Grant}, 32'd0);

    // simultaneous first request after reset
    do_reset();
    Lesen0 = 1; Lesen1 = 1;
    step();
    check("simul_first", {30'd0, Grant}, 32'd1);
    Lesen0 = 0;
    step();
    check("simul_handoff", {30'd0, Grant}, 32'd2);

    // write-back then fill on port 1 while port 0 waits
    do_reset();
    Schreiben1 = 1;
    step();
    Lesen0 = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin Schreiben1 = 0; Lesen1 = 1; end
      RAMDatenGeschrieben = (i < 4); RAMDatenGelesen = (i >= 4);
      #1;
      check("wbfill_grant", {30'd0, Grant}, 32'd2);
      check("wbfill_noack0", {30'd0, DatenGelesen0, DatenGeschrieben0}, 32'd0);
      step();
    end
    RAMDatenGeschrieben = 0; RAMDatenGelesen = 0; Lesen1 = 0;
    step();
    check("wbfill_next", {30'd0, Grant}, 32'd1);

    // data isolation
    do_reset();
    Lesen0 = 1;
    step();
    Schreiben1 = 1; SchreibDaten1 = 32'hCAFEF00D; SchreibDaten0 = 32'h12345678;
    RAMLesDaten = 32'hDEADBEEF; RAMDatenGelesen = 1;
    #1;
    check("iso_rdata0", LesDaten0, 32'hDEADBEEF);
    check("iso_rdata1", LesDaten1, 32'd0);
    check("iso_wdata", RAMSchreibDaten, 32'h12345678);
    check("iso_ack1", {31'd0, DatenGelesen1}, 32'd0);
    step();

    // reset mid-burst on port 1
    do_reset();
    Lesen1 = 1;
    step();
    check("midrst_own", {30'd0, Grant}, 32'd2);
    RAMDatenGelesen = 1;
    step();
    step();
    RAMDatenGelesen = 0; Reset = 1;
    step();
    check("midrst_grant", {30'd0, Grant}, 32'd0);
    check("midrst_ramrd", {31'd0, RAMLesen}, 32'd0);
    Reset = 0; Lesen0 = 1;
    step();
    check("midrst_after", {30'd0, Grant}, 32'd1);

    // continuous contention: six transactions alternate 0,1,0,1,0,1
    do_reset();
    Lesen0 = 1; Lesen1 = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      check("contend_order", {30'd0, Grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (Grant == 2'b01) Lesen0 = 0; else Lesen1 = 0;
      step();
      Lesen0 = 1; Lesen1 = 1;
    end

    // randomized traffic
    do_reset();
    h0 = 0; h1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (h0 == 0) begin
        h0 = $urandom_range(1, 12);
        Schreiben0 = $urandom_range(0, 2) == 0;
        Lesen0     = $urandom_range(0, 2) == 0;
      end else h0--;
      if (h1 == 0) begin
        h1 = $urandom_range(1, 12);
        Schreiben1 = $urandom_range(0, 2) == 0;
        Lesen1     = $urandom_range(0, 2) == 0;
      end else h1--;
      Adresse0 = $urandom; Adresse1 = $urandom;
      SchreibDaten0 = $urandom; SchreibDaten1 = $urandom;
      RAMLesDaten = $urandom;
      RAMDatenGeschrieben = $urandom_range(0, 1);
      RAMDatenGelesen     = $urandom_range(0, 1);
      Reset = ($urandom_range(0, 199) == 0);
      step();
    end
    Reset = 0;
    clear_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
